// File: rtl/zap_wb_ram_slave_if.sv
// Wishbone B3 bundle between the ZAP external-bus master and zap_wb_ram_slave.
// Signal names are given from the slave's point of view.
interface zap_wb_ram_slave_if;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic        i_wb_we;
  logic [3:0]  i_wb_sel;
  logic [31:0] i_wb_adr;
  logic [31:0] i_wb_dat;
  logic [2:0]  i_wb_cti;
  logic        o_wb_ack;
  logic [31:0] o_wb_dat;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_sel, i_wb_adr, i_wb_dat, i_wb_cti,
    input  o_wb_ack, o_wb_dat
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_sel, i_wb_adr, i_wb_dat, i_wb_cti,
    output o_wb_ack, o_wb_dat
  );
endinterface

// File: rtl/zap_wb_ram_slave.sv
// Wishbone B3 word-RAM responder: classic cycles plus CTI incrementing bursts,
// with a programmable number of wait states ahead of the first ack of a cycle.
module zap_wb_ram_slave #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  zap_wb_ram_slave_if.slave  wb,
  output logic               o_burst_active
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS_LOAD  = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_END  = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SINGLE, S_BURST} state_t;

  state_t          state_q, state_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            burst_q, burst_d;
  logic            ack_q, ack_d;
  logic [31:0]     dat_q;
  logic            busy_q;

  logic [31:0]     mem_q [DEPTH_WORDS];
  logic [AW-1:0]   adr_word;
  logic [AW-1:0]   rd_addr;
  logic [31:0]     rd_raw;
  logic [31:0]     rd_word;
  logic            rd_load;
  logic            wr_en;
  logic            unused_adr;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  assign adr_word   = wb.i_wb_adr[AW+1:2];
  assign unused_adr = ^{wb.i_wb_adr[31:AW+2], wb.i_wb_adr[1:0]};

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    burst_d = burst_q;
    ack_d   = 1'b0;
    rd_addr = addr_q;
    rd_load = 1'b0;
    wr_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (wb.i_wb_cyc && wb.i_wb_stb) begin
          addr_d  = adr_word;
          burst_d = (wb.i_wb_cti == CTI_INCR);
          rd_addr = adr_word;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            wcnt_d  = WS_LOAD;
          end else begin
            state_d = burst_d ? S_BURST : S_SINGLE;
            ack_d   = 1'b1;
            rd_load = !wb.i_wb_we;
          end
        end
      end
      S_WAIT: begin
        if (!wb.i_wb_cyc) begin
          state_d = S_IDLE;
        end else if (wcnt_q == 4'd0) begin
          state_d = burst_q ? S_BURST : S_SINGLE;
          ack_d   = 1'b1;
          rd_load = !wb.i_wb_we;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      S_SINGLE: begin
        state_d = S_IDLE;
        wr_en   = wb.i_wb_cyc && wb.i_wb_stb && wb.i_wb_we;
      end
      S_BURST: begin
        if (!wb.i_wb_cyc) begin
          state_d = S_IDLE;
        end else if (wb.i_wb_stb && ack_q) begin
          // Accepted beat: advance the wrapping word pointer and prefetch the next word.
          wr_en  = wb.i_wb_we;
          addr_d = addr_q + 1'b1;
          if (wb.i_wb_cti == CTI_END) begin
            state_d = S_IDLE;
          end else begin
            ack_d   = 1'b1;
            rd_addr = addr_d;
            rd_load = 1'b1;
          end
        end else if (wb.i_wb_stb) begin
          ack_d   = 1'b1;
          rd_load = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A write landing on the word being fetched at the same edge is forwarded.
  assign rd_raw  = mem_q[rd_addr];
  assign rd_word = (wr_en && (rd_addr == addr_q)) ?
                   merge_lanes(rd_raw, wb.i_wb_dat, wb.i_wb_sel) : rd_raw;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      wcnt_q  <= 4'd0;
      addr_q  <= '0;
      burst_q <= 1'b0;
      ack_q   <= 1'b0;
      dat_q   <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      burst_q <= burst_d;
      ack_q   <= ack_d;
      busy_q  <= (state_d == S_BURST);
      if (rd_load) dat_q <= rd_word;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wb.i_wb_sel[b]) mem_q[addr_q][8*b +: 8] <= wb.i_wb_dat[8*b +: 8];
      end
    end
  end

  assign wb.o_wb_ack    = ack_q;
  assign wb.o_wb_dat    = dat_q;
  assign o_burst_active = busy_q;

endmodule

// File: tb/tb_zap_wb_ram_slave.sv
// Bench for zap_wb_ram_slave: instance A (16 words, no wait states) and
// instance B (1024 words, 2 wait states) share one stimulus bus selected by 'which'.
module tb_zap_wb_ram_slave;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cnt = 0;
  always @(posedge clk) cnt <= cnt + 1;

  logic        which = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'd0, dat = 32'd0;
  logic [2:0]  cti = 3'b000;

  zap_wb_ram_slave_if bus_a ();
  zap_wb_ram_slave_if bus_b ();
  logic burst_a, burst_b;

  assign bus_a.i_wb_cyc = cyc & ~which;
  assign bus_a.i_wb_stb = stb;
  assign bus_a.i_wb_we  = we;
  assign bus_a.i_wb_sel = sel;
  assign bus_a.i_wb_adr = adr;
  assign bus_a.i_wb_dat = dat;
  assign bus_a.i_wb_cti = cti;
  assign bus_b.i_wb_cyc = cyc & which;
  assign bus_b.i_wb_stb = stb;
  assign bus_b.i_wb_we  = we;
  assign bus_b.i_wb_sel = sel;
  assign bus_b.i_wb_adr = adr;
  assign bus_b.i_wb_dat = dat;
  assign bus_b.i_wb_cti = cti;

  zap_wb_ram_slave #(.DEPTH_WORDS(16), .WAIT_STATES(0)) dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .wb(bus_a), .o_burst_active(burst_a));
  zap_wb_ram_slave #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .wb(bus_b), .o_burst_active(burst_b));

  logic        ack_m, busy_m;
  logic [31:0] dat_m;
  assign ack_m  = which ? bus_b.o_wb_ack : bus_a.o_wb_ack;
  assign dat_m  = which ? bus_b.o_wb_dat : bus_a.o_wb_dat;
  assign busy_m = which ? burst_b : burst_a;

  typedef struct {
    int          cyc;
    bit          rd;
    logic [31:0] dat;
    string       nm;
  } exp_t;
  exp_t expq[$];

  int checks   = 0;
  int failures = 0;

  logic [31:0] wbuf [16];
  logic [31:0] rbuf [16];

  function automatic void push(input int c, input bit rd, input logic [31:0] d, input string nm);
    exp_t e;
    e.cyc = c;
    e.rd  = rd;
    e.dat = d;
    e.nm  = nm;
    expq.push_back(e);
  endfunction

  // Scoreboard monitor: a beat is any cycle with cyc & stb & ack on the selected slave.
  always @(negedge clk) begin
    if (ack_m && cyc && stb) begin
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ack cycle=%0d got_ack=1 want_ack=0", cnt);
      end else begin
        exp_t e;
        e = expq.pop_front();
        if (e.cyc != cnt) begin
          failures++;
          $display("FAIL %s ack_cycle got=%0d want=%0d", e.nm, cnt, e.cyc);
        end
        if (e.rd) begin
          checks++;
          if (dat_m !== e.dat) begin
            failures++;
            $display("FAIL %s rdata got=%h want=%h", e.nm, dat_m, e.dat);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic drained(input string nm);
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL %s missing_acks got=0 want=%0d", nm, expq.size());
    end
    expq.delete();
  endtask

  task automatic single(input bit on_b, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] exp_d, input string nm);
    int ws;
    ws = on_b ? 2 : 0;
    step();
    which = on_b; cyc = 1'b1; stb = 1'b1; we = wr; sel = s; adr = a; dat = d; cti = 3'b000;
    push(cnt + 1 + ws, !wr, exp_d, nm);
    repeat (2 + ws) step();
    chk({nm, "_ack_one_cycle"}, 32'(ack_m), 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    drained(nm);
  endtask

  task automatic burst(input bit on_b, input bit wr, input logic [31:0] a0, input int n,
                       input int stall_at, input int stall_len, input int abort_at,
                       input string nm);
    int cur;
    bit done;
    done = 1'b0;
    step();
    which = on_b; cyc = 1'b1; stb = 1'b1; we = wr; sel = 4'hF; adr = a0; dat = wbuf[0];
    cti = 3'b010;
    cur = cnt + 1 + (on_b ? 2 : 0);
    for (int k = 0; k < n && !done; k++) begin
      while (cnt < cur) step();
      if (k == 0) chk({nm, "_busy"}, 32'(busy_m), 32'd1);
      adr = a0 + 32'(4 * k);
      dat = wbuf[k];
      cti = (k == n - 1) ? 3'b111 : 3'b010;
      if (k == abort_at) begin
        cyc = 1'b0;
        step();
        chk({nm, "_abort_ack"}, 32'(ack_m), 32'd0);
        chk({nm, "_abort_busy"}, 32'(busy_m), 32'd0);
        done = 1'b1;
      end else begin
        push(cur, !wr, rbuf[k], $sformatf("%s_beat%0d", nm, k));
        if (k == n - 1) begin
          step();
          chk({nm, "_end_ack"}, 32'(ack_m), 32'd0);
          chk({nm, "_end_busy"}, 32'(busy_m), 32'd0);
          done = 1'b1;
        end else if (k == stall_at) begin
          step();
          stb = 1'b0;
          for (int s = 0; s < stall_len - 1; s++) begin
            step();
            chk({nm, "_stall_ack"}, 32'(ack_m), 32'd0);
          end
          step();
          stb = 1'b1;
          chk({nm, "_stall_ack"}, 32'(ack_m), 32'd0);
          cur = cur + stall_len + 2;
        end else begin
          cur = cur + 1;
        end
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
    step();
    drained(nm);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle=%0d", cnt);
    $fatal(1, "timeout");
  end

  initial begin
    step();
    step();
    chk("rst_ack_a", 32'(bus_a.o_wb_ack), 32'd0);
    chk("rst_ack_b", 32'(bus_b.o_wb_ack), 32'd0);
    chk("rst_dat_a", bus_a.o_wb_dat, 32'd0);
    chk("rst_dat_b", bus_b.o_wb_dat, 32'd0);
    chk("rst_busy_a", 32'(burst_a), 32'd0);
    chk("rst_busy_b", 32'(burst_b), 32'd0);
    rst_n = 1'b1;
    step();

    // classic write/read, no wait states
    single(1'b0, 1'b1, 32'h10, 32'hA5A5_5A5A, 4'hF, 32'd0, "cls_wr");
    single(1'b0, 1'b0, 32'h10, 32'd0, 4'hF, 32'hA5A5_5A5A, "cls_rd");

    // byte lanes
    single(1'b0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF, 32'd0, "lane_fill");
    single(1'b0, 1'b1, 32'h20, 32'h1122_3344, 4'b0101, 32'd0, "lane_wr");
    single(1'b0, 1'b0, 32'h20, 32'd0, 4'hF, 32'hFF22_FF44, "lane_rd");

    // burst read with two wait states on instance B
    single(1'b1, 1'b1, 32'h40, 32'hB000_0010, 4'hF, 32'd0, "b_pre0");
    single(1'b1, 1'b1, 32'h44, 32'hB000_0011, 4'hF, 32'd0, "b_pre1");
    single(1'b1, 1'b1, 32'h48, 32'hB000_0012, 4'hF, 32'd0, "b_pre2");
    single(1'b1, 1'b1, 32'h4C, 32'hB000_0013, 4'hF, 32'd0, "b_pre3");
    rbuf[0] = 32'hB000_0010; rbuf[1] = 32'hB000_0011;
    rbuf[2] = 32'hB000_0012; rbuf[3] = 32'hB000_0013;
    burst(1'b1, 1'b0, 32'h40, 4, -1, 0, -1, "ws_burst_rd");

    // cyc dropped while waiting
    step();
    which = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h40; cti = 3'b010;
    step();
    cyc = 1'b0; stb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_abort_ack", 32'(ack_m), 32'd0);
    end
    chk("wait_abort_busy", 32'(busy_m), 32'd0);
    drained("wait_abort");

    // 16-word instance: prefill, wrapping burst write, full readback
    for (int i = 0; i < 16; i++) wbuf[i] = 32'hC0DE_0000 | 32'(i);
    burst(1'b0, 1'b1, 32'h0, 16, -1, 0, -1, "prefill");
    wbuf[0] = 32'hDEAD_0000; wbuf[1] = 32'hDEAD_0001;
    wbuf[2] = 32'hDEAD_0002; wbuf[3] = 32'hDEAD_0003;
    burst(1'b0, 1'b1, 32'h38, 4, -1, 0, -1, "wrap_wr");
    for (int i = 0; i < 16; i++) rbuf[i] = 32'hC0DE_0000 | 32'(i);
    rbuf[14] = 32'hDEAD_0000; rbuf[15] = 32'hDEAD_0001;
    rbuf[0]  = 32'hDEAD_0002; rbuf[1]  = 32'hDEAD_0003;
    burst(1'b0, 1'b0, 32'h0, 16, -1, 0, -1, "wrap_rd");

    // master stall after the second beat
    rbuf[0] = 32'hDEAD_0002; rbuf[1] = 32'hDEAD_0003;
    rbuf[2] = 32'hC0DE_0002; rbuf[3] = 32'hC0DE_0003;
    burst(1'b0, 1'b0, 32'h0, 4, 1, 2, -1, "stall_rd");

    // abort during the third beat of a write burst
    wbuf[0] = 32'hAB00_0000; wbuf[1] = 32'hAB00_0001;
    wbuf[2] = 32'hAB00_0002; wbuf[3] = 32'hAB00_0003;
    burst(1'b0, 1'b1, 32'h10, 4, -1, 0, 2, "abort_wr");
    rbuf[0] = 32'hAB00_0000; rbuf[1] = 32'hAB00_0001;
    rbuf[2] = 32'hC0DE_0006; rbuf[3] = 32'hC0DE_0007;
    burst(1'b0, 1'b0, 32'h10, 4, -1, 0, -1, "abort_chk");

    // asynchronous reset in the middle of a burst
    step();
    which = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0; cti = 3'b010;
    push(cnt + 1, 1'b1, 32'hDEAD_0002, "rst_burst_beat0");
    step();
    step();
    chk("rst_mid_pre_ack", 32'(ack_m), 32'd1);
    chk("rst_mid_pre_busy", 32'(busy_m), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ack", 32'(ack_m), 32'd0);
    chk("rst_mid_busy", 32'(busy_m), 32'd0);
    chk("rst_mid_dat", dat_m, 32'd0);
    cyc = 1'b0; stb = 1'b0; cti = 3'b000;
    step();
    step();
    rst_n = 1'b1;
    step();
    drained("rst_mid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/zap_wb_ram_slave.md
Name: zap_wb_ram_slave

Overview:
- Wishbone B3 responder (slave) for the external bus driven by the ZAP processor top level.
- Backs a single-ported word RAM and services classic single-beat cycles and CTI incrementing bursts, as issued by the cache line-fill and write-back paths.
- Adds programmable first-beat wait states.
- Serves as the memory model and as a synthesizable on-chip RAM for SoC builds.

Parameters:
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; must be a power of 2, min 4. AW = log2(DEPTH_WORDS).
- WAIT_STATES, 0: extra cycles inserted before the first ack of each cycle (0..15).

Ports:
- i_clk  in  1  core clock; all logic on rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_wb_cyc  in  1  bus cycle valid.
- i_wb_stb  in  1  strobe.
- i_wb_we  in  1  1 = write, 0 = read.
- i_wb_sel  in  4  byte lane enables; bit n covers dat[8n+7:8n].
- i_wb_adr  in  32  byte address; word index = adr[AW+1:2]; adr[1:0] and adr[31:AW+2] ignored.
- i_wb_dat  in  32  write data.
- i_wb_cti  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst; others treated as 000.
- o_wb_ack  out  1  registered acknowledge.
- o_wb_dat  out  32  registered read data, valid when o_wb_ack=1 and the beat is a read.
- o_burst_active  out  1  high while the FSM is in BURST.

Behaviour:
Reset (async assert, sync deassert assumed upstream):
- o_wb_ack=0, o_wb_dat=0, o_burst_active=0.
- FSM=IDLE, wait counter=0, burst address=0.
- RAM contents are not reset.

FSM states: IDLE, WAIT, SINGLE, BURST.

IDLE:
- Samples cyc&stb.
- If WAIT_STATES>0, go to WAIT and load the counter with WAIT_STATES-1.
- If WAIT_STATES=0, go to SINGLE (cti≠010) or BURST (cti=010).
- Latch word address and cti class.

WAIT:
- Count down; at 0, go to SINGLE or BURST per the latched class.
- If cyc drops, go to IDLE.

SINGLE:
- o_wb_ack=1 for exactly one cycle.
- Read: o_wb_dat = RAM[addr].
- Write: lanes with sel=1 are updated at the end of the ack cycle; o_wb_dat holds its previous value.
- Next state is IDLE unconditionally, so a following request is sampled no earlier than the next cycle.
- Single-access latency: ack in cycle T+1+WAIT_STATES where T = first cycle cyc&stb is sampled in IDLE; back-to-back period = WAIT_STATES+2 cycles.

BURST:
- A beat is accepted on any cycle with cyc&stb&ack.
- On each accepted beat: write (if we, per sel) to the current burst address, then increment the word address modulo DEPTH_WORDS (wrap to word 0).
- Read data for the next address is presented with the next ack, with no bubble.
- we and sel are sampled per beat.
- Accepted beat with cti=111: ack drops the next cycle, go to IDLE.
- stb low while cyc high: ack drops the next cycle; no write; address unchanged. When stb returns, ack resumes on the following cycle with the same address.
- Wait states apply to the first beat only.

Abort and read-after-write:
- cyc low in any state: go to IDLE the next cycle with ack=0. A write coinciding with cyc=0 is not performed.
- A read of an address written in an earlier cycle returns the new data (RAM write has priority, same-edge read-after-write bypass).

Test Plan:
- Reset then classic write adr=0x10, dat=0xA5A5_5A5A, sel=1111, WAIT_STATES=0 -> ack exactly one cycle, at T+1. Classic read adr=0x10 -> o_wb_dat=0xA5A5_5A5A with ack.
- Byte lanes: write 0x1122_3344 sel=0101 over existing 0xFFFF_FFFF -> readback 0xFF22_FF44.
- Burst read of 4 beats from adr=0x40 (cti 010,010,010,111), WAIT_STATES=2 -> first ack at T+3, then 3 consecutive acks; data = words 0x10..0x13; ack low the cycle after the fourth beat.
- Wrap: DEPTH_WORDS=16, burst write of 4 beats starting adr=0x38 -> words 14,15,0,1 are written; words 2..13 unchanged.
- Master stall: burst with stb low for 2 cycles after beat 2 -> ack low for those cycles; beat 3 returns word start+2; no skipped or duplicated word.
- Abort: cyc dropped during WAIT and mid-burst write -> no ack afterward, o_burst_active=0 the next cycle, no RAM write on the abort cycle.
- Reset asserted mid-burst -> o_wb_ack and o_burst_active go to 0 immediately.
